vec_mux_arbiter: RTL

- Shares one registered 2:1 vector datapath between two packet sources (source 0 and source 1). Each source offers DIMENSION*WIDTH-bit beats.
- Packet-level round-robin arbitration with valid/ready handshakes on both sides; a grant is held until the packet's last beat transfers.
- Sits in front of the downstream vector processing stage, in the position the plain registered select mux occupied. It generates the select internally and adds flow control.

---
 rtl/vec_mux_arb_pkg.sv | 14 +
 rtl/vec_out_reg.sv | 35 +++
 rtl/vec_mux_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vec_mux_arb_pkg.sv
// Shared types and constants for the two-source packet arbiter in front of the vector stage.
package vec_mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_e;

   localparam logic SRC0    = 1'b0;
   localparam logic SRC1    = 1'b1;
   localparam int   STATS_W = 16;

endpackage

// File: rtl/vec_out_reg.sv
// Output register stage: loads an accepted beat, drains on m_ready, holds while stalled.
module vec_out_reg #(
   parameter int DW = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic signed [DW-1:0] load_data,
   input  logic                 load_last,
   input  logic                 load_src,
   input  logic                 m_ready,
   output logic                 m_valid,
   output logic signed [DW-1:0] m_data,
   output logic                 m_last,
   output logic                 m_src
);

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_src   <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
         m_last  <= load_last;
         m_src   <= load_src;
      end else if (m_valid && m_ready) begin
         // payload fields keep their last value once drained
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/vec_mux_arbiter.sv
// Packet-level round-robin arbiter sharing one registered vector path between two sources.
// Optional per-source packet counters when VEC_MUX_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no grant; picks a source when en=1 and a valid is seen
// GRANT0 | source 0 owns the datapath until its last beat transfers
// GRANT1 | source 1 owns the datapath until its last beat transfers
module vec_mux_arbiter
   import vec_mux_arb_pkg::*;
#(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           s0_valid,
   output logic                           s0_ready,
   input  logic signed [DIMENSION*WIDTH-1:0] s0_data,
   input  logic                           s0_last,
   input  logic                           s1_valid,
   output logic                           s1_ready,
   input  logic signed [DIMENSION*WIDTH-1:0] s1_data,
   input  logic                           s1_last,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic signed [DIMENSION*WIDTH-1:0] m_data,
   output logic                           m_last,
   output logic                           m_src
`ifdef VEC_MUX_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0]             pkt_cnt0,
   output logic [STATS_W-1:0]             pkt_cnt1
`endif
);

   localparam int DW = DIMENSION * WIDTH;

   arb_state_e state, state_nxt;
   logic prio, prio_nxt;
   logic out_free, xfer0, xfer1, load;
   logic signed [DW-1:0] load_data;
   logic load_last, load_src;

   assign out_free = !m_valid || m_ready;
   assign s0_ready = (state == GRANT0) && out_free;
   assign s1_ready = (state == GRANT1) && out_free;
   assign xfer0    = s0_valid && s0_ready;
   assign xfer1    = s1_valid && s1_ready;
   assign load     = xfer0 || xfer1;

   always_comb begin
      load_data = s0_data;
      load_last = s0_last;
      load_src  = SRC0;
      if (xfer1) begin
         load_data = s1_data;
         load_last = s1_last;
         load_src  = SRC1;
      end
   end

   always_comb begin
      state_nxt = state;
      prio_nxt  = prio;
      case (state)
         IDLE: begin
            if (en) begin
               // prio names the source served last, so a tie goes to the other one
               if (s0_valid && s1_valid) state_nxt = prio ? GRANT0 : GRANT1;
               else if (s0_valid)        state_nxt = GRANT0;
               else if (s1_valid)        state_nxt = GRANT1;
            end
         end
         GRANT0: begin
            if (xfer0 && s0_last) begin
               prio_nxt = SRC0;
               if (en && s1_valid)      state_nxt = GRANT1;
               else if (en && s0_valid) state_nxt = GRANT0;
               else                     state_nxt = IDLE;
            end
         end
         GRANT1: begin
            if (xfer1 && s1_last) begin
               prio_nxt = SRC1;
               if (en && s0_valid)      state_nxt = GRANT0;
               else if (en && s1_valid) state_nxt = GRANT1;
               else                     state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         prio  <= SRC1;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
      end
   end

   vec_out_reg #(
      .DW (DW)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .load_src  (load_src),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .m_src     (m_src)
   );

`ifdef VEC_MUX_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (xfer0 && s0_last) pkt_cnt0 <= pkt_cnt0 + 1'b1;
         if (xfer1 && s1_last) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
   end
`endif

endmodule
